// File: rtl/edge_drv_pkg.sv
// Shared types and constants for the edge pattern driver.
package edge_drv_pkg;

  // Replay controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } drv_state_t;

  localparam int DRV_DEFAULT_DEPTH = 8;

endpackage

// File: rtl/bit_fifo.sv
// Single-bit sample FIFO with occupancy count; pointers wrap naturally.
// Pushes when full and pops when empty are ignored.
module bit_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     push_bit,
  input  logic                     pop,
  output logic                     head_bit,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign head_bit = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_bit;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO state registers; reset discards all queued samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/edge_pattern_driver.sv
// Replays queued single-bit samples onto a, one per clock, and reports
// sampled-edge flags plus a saturating rising-edge count.
//
// Input port handshake: a sample is taken on any posedge where
// in_valid && in_ready; in_ready depends only on occupancy (not on a
// same-cycle pop) and in_valid may be raised independently of in_ready.
module edge_pattern_driver
  import edge_drv_pkg::*;
#(
  parameter int DEPTH = DRV_DEFAULT_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_bit,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     clear,
  output logic                     busy,
  output logic                     a,
  output logic                     rose,
  output logic                     fell,
  output logic                     stable,
  output logic [CNT_W-1:0]         rise_cnt,
  output logic [$clog2(DEPTH):0]   level,
  output drv_state_t               dbg_state
);

  drv_state_t       state_q, state_d;
  logic             a_q, a_d;
  logic             a_prev_q, a_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;
  logic             head_bit;
  logic             fifo_full;
  logic             fifo_empty;

  bit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_valid && in_ready),
    .push_bit (in_bit),
    .pop      (pop),
    .head_bit (head_bit),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign in_ready  = !fifo_full;
  assign busy      = (state_q == RUN) || (state_q == PAUSE);
  assign a         = a_q;
  assign rose      = a_q & ~a_prev_q;
  assign fell      = ~a_q & a_prev_q;
  assign stable    = (a_q == a_prev_q);
  assign rise_cnt  = cnt_q;
  assign dbg_state = state_q;

  // Replay FSM: pause beats the empty check, which beats a pop.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    a_prev_d = a_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !fifo_empty) state_d = RUN;
      end
      RUN: begin
        if (pause) begin
          state_d = PAUSE;
        end else if (fifo_empty) begin
          state_d = IDLE;
        end else begin
          pop = 1'b1;
          a_d = head_bit;
        end
      end
      PAUSE: begin
        if (!pause) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Rising-edge counter: counts loads of 1 over 0, saturates, clear wins.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (pop && head_bit && !a_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, waveform and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= 1'b0;
      a_prev_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      a_prev_q <= a_prev_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
